// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: access sizes,
// controller FSM states, lane-enable generation and load extension.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BEAT2 = 1'b1
  } state_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Lanes touched across the two-word window starting at byte offset off.
  function automatic logic [7:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    return {4'b0000, size_mask(size)} << off;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] size,
                                           input logic uns);
    logic [31:0] r;
    case (size)
      SZ_B:    r = {{24{~uns & d[7]}}, d[7:0]};
      SZ_H:    r = {{16{~uns & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Inferred single-port byte-enable RAM, read-first, one-cycle read latency.
module dmem_bram #(
  parameter int unsigned DEPTH_WORDS = 65536,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   din,
  output logic [31:0]   dout
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] dout_q;

  always_ff @(posedge clk) begin
    dout_q <= mem_q[addr];
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem_q[addr][8*i +: 8] <= din[8*i +: 8];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/dmem_ctrl.sv
// RV32 data-memory controller: sized loads/stores over a byte-enable BRAM,
// misaligned accesses split into two word beats, range/size errors flagged.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DEPTH_WORDS = 65536,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned     BW         = $clog2(DEPTH_WORDS);
  localparam longint unsigned BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd4;

  state_t      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  size_t       size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic        split_q, split_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  hi_we_q, hi_we_d;
  logic [31:0] hi_din_q, hi_din_d;
  logic [BW-1:0] hi_addr_q, hi_addr_d;

  logic          accept, mis, err;
  logic [ADDR_W:0] nbytes_m1, end_b;
  logic [7:0]    lanes;
  logic [63:0]   sh_data;
  logic [31:0]   rep_data;
  logic [3:0]    bram_we;
  logic [BW-1:0] bram_addr;
  logic [31:0]   bram_din, bram_dout;
  logic [63:0]   pair;
  logic [31:0]   lane_data;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    nbytes_m1 = '0;
    case (req_size)
      SZ_B:    nbytes_m1 = '0;
      SZ_H:    nbytes_m1 = (ADDR_W+1)'(1);
      default: nbytes_m1 = (ADDR_W+1)'(3);
    endcase
    end_b   = {1'b0, req_addr} + nbytes_m1;
    mis     = ((req_size == SZ_H) & req_addr[0]) |
              ((req_size == SZ_W) & (req_addr[1:0] != 2'b00));
    err     = (req_size == 2'b11) | (64'(end_b) >= BYTE_LIMIT) | (mis & !MISALIGN_EN);
    lanes   = lane_en(req_size, req_addr[1:0]);
    sh_data = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
    case (req_size)
      SZ_B:    rep_data = {4{req_wdata[7:0]}};
      SZ_H:    rep_data = {2{req_wdata[15:0]}};
      default: rep_data = req_wdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    we_d        = we_q;
    split_d     = split_q;
    lo_d        = lo_q;
    hi_we_d     = hi_we_q;
    hi_din_d    = hi_din_q;
    hi_addr_d   = hi_addr_q;
    bram_we     = '0;
    bram_addr   = BW'(req_addr[ADDR_W-1:2]);
    bram_din    = rep_data;
    case (state_q)
      IDLE: begin
        if (accept) begin
          size_d  = size_t'(req_size);
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          we_d    = req_we;
          split_d = 1'b0;
          if (err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (mis) begin
            // Beat 1 now on word w; beat 2 on w+1 is replayed from saved state.
            bram_we   = req_we ? lanes[3:0] : 4'b0000;
            bram_din  = sh_data[31:0];
            hi_we_d   = req_we ? lanes[7:4] : 4'b0000;
            hi_din_d  = sh_data[63:32];
            hi_addr_d = bram_addr + BW'(1);
            split_d   = 1'b1;
            state_d   = BEAT2;
          end else begin
            bram_we     = req_we ? lanes[3:0] : 4'b0000;
            rsp_valid_d = 1'b1;
          end
        end
      end
      BEAT2: begin
        bram_addr   = hi_addr_q;
        bram_we     = hi_we_q;
        bram_din    = hi_din_q;
        lo_d        = bram_dout;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      off_q       <= '0;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      lo_q        <= '0;
      hi_we_q     <= '0;
      hi_din_q    <= '0;
      hi_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      we_q        <= we_d;
      split_q     <= split_d;
      lo_q        <= lo_d;
      hi_we_q     <= hi_we_d;
      hi_din_q    <= hi_din_d;
      hi_addr_q   <= hi_addr_d;
    end
  end

  dmem_bram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(BW)) u_bram (
    .clk  (clk),
    .we   (bram_we),
    .addr (bram_addr),
    .din  (bram_din),
    .dout (bram_dout)
  );

  // BRAM output is live in the response cycle; split loads join it with the saved low word.
  always_comb begin
    pair      = split_q ? {bram_dout, lo_q} : {32'b0, bram_dout};
    lane_data = 32'(pair >> {off_q, 3'b000});
    rsp_rdata = '0;
    if (rsp_valid_q && !rsp_err_q && !we_q) rsp_rdata = load_ext(lane_data, size_q, uns_q);
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed requests push expected responses,
// per-instance monitors pop and compare data, error flag and response cycle.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [17:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        sel0 = 1'b0;

  logic        rdy1, v1, err1, rdy0, v0, err0;
  logic [31:0] rd1, rd0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(18), .DEPTH_WORDS(65536), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel0), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(v1), .rsp_rdata(rd1), .rsp_err(err1)
  );

  dmem_ctrl #(.ADDR_W(18), .DEPTH_WORDS(1024), .MISALIGN_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel0), .req_ready(rdy0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(v0), .rsp_rdata(rd0), .rsp_err(err0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          id;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  exp_t e1, e0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %0s id=%0d: got 0x%08h expected 0x%08h", nm, id, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && v1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_rsp dut: rdata 0x%08h err %0b with no request pending", rd1, err1);
      end else begin
        e1 = q1.pop_front();
        chk(e1.id, "rdata", rd1, e1.rdata);
        chk(e1.id, "err", 32'(err1), 32'(e1.err));
        chk(e1.id, "rsp_cycle", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_rsp dut0: rdata 0x%08h err %0b with no request pending", rd0, err0);
      end else begin
        e0 = q0.pop_front();
        chk(e0.id, "rdata0", rd0, e0.rdata);
        chk(e0.id, "err0", 32'(err0), 32'(e0.err));
        chk(e0.id, "rsp_cycle0", 32'(cyc), 32'(e0.cyc));
      end
    end
  end

  task automatic issue(input bit to0, input bit we, input logic [17:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input bit uns, input logic [31:0] exp_rd,
                       input bit exp_err, input int lat, input int id);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    sel0 = to0; req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wd; req_size = sz; req_unsigned = uns;
    while ((to0 ? rdy0 : rdy1) !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_chk++;
      $display("FAIL ready_timeout id=%0d: req_ready low for %0d cycles", id, guard);
      req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat; e.id = id;
    if (to0) q0.push_back(e);
    else q1.push_back(e);
    @(posedge clk);
  endtask

  task automatic st(input logic [17:0] a, input logic [31:0] d, input logic [1:0] sz,
                    input int lat, input int id);
    issue(1'b0, 1'b1, a, d, sz, 1'b0, 32'h0, 1'b0, lat, id);
  endtask

  task automatic ld(input logic [17:0] a, input logic [1:0] sz, input bit uns,
                    input logic [31:0] exp, input int lat, input int id);
    issue(1'b0, 1'b0, a, 32'h0, sz, uns, exp, 1'b0, lat, id);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q1.size() != 0 || q0.size() != 0) && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (q1.size() + q0.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d responses missing, required 0", q1.size() + q0.size());
      q1.delete();
      q0.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk(0, "rst_valid", 32'(v1), 32'd0);
    chk(0, "rst_ready", 32'(rdy1), 32'd1);
    chk(0, "rst_rdata", rd1, 32'h0);
    chk(0, "rst_err", 32'(err1), 32'd0);
    rst_n = 1'b1;

    // aligned store then back-to-back loads
    st(18'h00100, 32'hDEADBEEF, 2'b10, 1, 1);
    ld(18'h00103, 2'b00, 1'b0, 32'hFFFFFFDE, 1, 2);
    ld(18'h00103, 2'b00, 1'b1, 32'h000000DE, 1, 3);
    ld(18'h00102, 2'b01, 1'b0, 32'hFFFFDEAD, 1, 4);
    ld(18'h00100, 2'b10, 1'b0, 32'hDEADBEEF, 1, 5);

    // byte-enable integrity
    st(18'h00200, 32'h11223344, 2'b10, 1, 10);
    st(18'h00201, 32'hFFFFFFAA, 2'b00, 1, 11);
    st(18'h00202, 32'hFFFF7788, 2'b01, 1, 12);
    ld(18'h00200, 2'b10, 1'b0, 32'h7788AA44, 1, 13);

    // misaligned split accesses
    st(18'h00304, 32'h11111111, 2'b10, 1, 20);
    st(18'h00308, 32'h22222222, 2'b10, 1, 21);
    st(18'h00305, 32'hCAFEF00D, 2'b10, 2, 22);
    @(negedge clk);
    chk(22, "beat2_ready", 32'(rdy1), 32'd0);
    ld(18'h00304, 2'b10, 1'b0, 32'hFEF00D11, 1, 23);
    ld(18'h00308, 2'b10, 1'b0, 32'h222222CA, 1, 24);
    ld(18'h00305, 2'b10, 1'b0, 32'hCAFEF00D, 2, 25);
    ld(18'h00307, 2'b01, 1'b0, 32'hFFFFCAFE, 2, 26);
    ld(18'h00307, 2'b01, 1'b1, 32'h0000CAFE, 2, 27);

    // errors: illegal size, out of range, no write on error
    issue(1'b0, 1'b0, 18'h00050, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1, 30);
    issue(1'b0, 1'b1, 18'h00054, 32'h12345678, 2'b11, 1'b0, 32'h0, 1'b1, 1, 31);
    st(18'h3FFFC, 32'h0BADF00D, 2'b10, 1, 32);
    issue(1'b0, 1'b1, 18'h3FFFE, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, 1'b1, 1, 33);
    issue(1'b0, 1'b0, 18'h3FFFE, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1, 34);
    ld(18'h3FFFC, 2'b10, 1'b0, 32'h0BADF00D, 1, 35);
    ld(18'h3FFFF, 2'b00, 1'b1, 32'h0000000B, 1, 36);
    issue(1'b0, 1'b0, 18'h3FFFF, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1, 37);

    // instance without misaligned support
    issue(1'b1, 1'b0, 18'h00001, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1, 40);
    issue(1'b1, 1'b1, 18'h00002, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b1, 1, 41);
    issue(1'b1, 1'b1, 18'h00004, 32'h0000A5A5, 2'b01, 1'b0, 32'h0, 1'b0, 1, 42);
    issue(1'b1, 1'b0, 18'h00004, 32'h0, 2'b01, 1'b1, 32'h0000A5A5, 1'b0, 1, 43);
    issue(1'b1, 1'b0, 18'h00005, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1, 44);
    issue(1'b1, 1'b0, 18'h01000, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1, 45);

    // sign / zero extension edges
    st(18'h00010, 32'h00008000, 2'b01, 1, 50);
    ld(18'h00010, 2'b01, 1'b0, 32'hFFFF8000, 1, 51);
    ld(18'h00010, 2'b01, 1'b1, 32'h00008000, 1, 52);
    st(18'h00012, 32'h0000007F, 2'b00, 1, 53);
    ld(18'h00012, 2'b00, 1'b0, 32'h0000007F, 1, 54);
    ld(18'h00011, 2'b00, 1'b0, 32'hFFFFFF80, 1, 55);
    idle();
    drain();

    // reset during the second beat of a misaligned store
    st(18'h00404, 32'h55555555, 2'b10, 1, 60);
    st(18'h00400, 32'h00000000, 2'b10, 1, 61);
    st(18'h00402, 32'hCAFEF00D, 2'b10, 2, 62);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk(62, "reset_valid", 32'(v1), 32'd0);
    chk(62, "reset_ready", 32'(rdy1), 32'd1);
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(62, "post_reset_ready", 32'(rdy1), 32'd1);
    ld(18'h00404, 2'b10, 1'b0, 32'h55555555, 1, 63);
    ld(18'h00400, 2'b10, 1'b0, 32'hF00D0000, 1, 64);
    idle();
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory controller between the RV32 MEM stage and a byte-enabled single-port block RAM, with a valid/ready request port and a registered response port.
- Handles sb/sh/sw stores through byte enables and lb/lbu/lh/lhu/lw loads with correct sign or zero extension.
- Absorbs the one-cycle BRAM read latency.
- Splits misaligned accesses into two word beats.
- Flags out-of-range and illegal requests with an error bit instead of touching memory.

Parameters:
- ADDR_W, 18, byte-address width of req_addr.
- DEPTH_WORDS, 65536, number of 32-bit words in the RAM; legal byte addresses are 0 to 4*DEPTH_WORDS-1.
- MISALIGN_EN, 1, 1 = split misaligned accesses into two beats; 0 = misaligned request returns rsp_err.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; handshake = req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  1 = zero-extend load result (lbu/lhu), 0 = sign-extend.
- rsp_valid  out  1  one-cycle pulse: load data or store acknowledge valid.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected: illegal size, out of range, or misaligned with MISALIGN_EN=0.

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, no BRAM write pending. Reset mid-split abandons the second beat; a half-written misaligned store is not completed.
- FSM states:
  - IDLE: req_ready=1.
  - BEAT2: req_ready=0.
- Misaligned test: (size=01 & addr[0]) | (size=10 & addr[1:0]!=0). Word index w=addr[ADDR_W-1:2]; offset o=addr[1:0].
- Error check, done at accept: size=11; or end byte (addr+bytes-1) >= 4*DEPTH_WORDS; or misaligned with MISALIGN_EN=0. On error: no BRAM write, rsp_valid=1 next cycle with rsp_err=1 and rsp_rdata=0.
- Aligned access accepted at cycle t:
  - Store: BRAM written at t. Byte enables: sb -> 1<<o; sh -> 0011 or 1100; sw -> 1111. Data is replicated into every lane.
  - Load: BRAM read issued at t.
  - Response: rsp_valid at t+1.
  - State stays IDLE, so back-to-back accepts every cycle are allowed; pipelined throughput is 1/cycle.
- Misaligned access accepted at t (MISALIGN_EN=1): state goes to BEAT2 at t+1, IDLE at t+2; rsp_valid at t+2; next accept possible at t+2.
  - Store: beat 1 at t writes word w with lanes o..3. Beat 2 at t+1 writes word w+1 with the remaining low lanes. Data is the 8-byte vector ({32'b0, wdata} << 8*o), split into low and high words.
  - Load: word w is read at t and captured at t+1. Word w+1 is read at t+1. Result is byte-select of ({word_w1, word_w} >> 8*o).
- Load extension: byte -> bit 7 replicated (or zero) into [31:8]; half -> bit 15 into [31:16]; word unchanged.
- Request fields (size, unsigned, offset, we, err, split flag) are registered at accept. Inputs may change after the handshake.
- Store acknowledge: rsp_rdata=0, rsp_err=0.
- BRAM timing: read-first, one-cycle read latency. Only one BRAM operation per cycle, so accepts are blocked in BEAT2.
- req_valid while req_ready=0: ignored. The requester must hold the request until the handshake.

Decomposition:
- Shared package dmem_pkg:
  - typedef enum size_t {SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10}.
  - FSM state enum {IDLE, BEAT2}.
  - functions for lane-enable generation and load extension.
- Sub-module dmem_bram: inferred byte-enable single-port RAM, parameter DEPTH_WORDS, ports clk, we[3:0], addr, din, dout. This replaces the vendor IP instance so depth is parametric.

Test Plan:
1. Reset: assert rst_n=0 during a BEAT2 cycle -> rsp_valid=0 immediately, req_ready=1 after release, second word unmodified.
2. Aligned store/load: sw 0xDEADBEEF @0x100, then lb @0x103 -> 0xFFFFFFDE; lbu @0x103 -> 0x000000DE; lh @0x102 -> 0xFFFFDEAD; each rsp at accept+1; back-to-back accepts every cycle.
3. Byte-enable integrity: sw 0x11223344 @0x200, sb 0xAA @0x201, sh 0x7788 @0x202 -> lw @0x200 = 0x7788AA44.
4. Misaligned (MISALIGN_EN=1): sw 0xCAFEF00D @0x305 -> rsp at accept+2, req_ready=0 for one cycle; lw @0x304 = 0xFEF00Dxx (xx = prior byte 0x304 unchanged), lw @0x308 low byte = 0xCA; lw @0x305 = 0xCAFEF00D.
5. Errors: size=11 -> rsp_err=1, rdata=0; lw at 4*DEPTH_WORDS-2 -> rsp_err=1 and no write; with MISALIGN_EN=0, lh @0x1 -> rsp_err=1.
6. Sign edge: sh 0x8000 @0x10; lh -> 0xFFFF8000, lhu -> 0x00008000; sb 0x7F, lb -> 0x0000007F.
